// File: rtl/ramp_stream_checker.sv
// ramp_stream_checker
//   Self-check stage for the sequential table read-out stream. Verifies that
//   the incoming bytes form a modulo-2^WIDTH incrementing ramp. It keeps
//   saturating match/error/wrap statistics and reports whether it is locked.
//
//   Optional feature (macro RAMP_CHK_ERR_LOG_EN): holds a record of the
//   first mismatch since reset/clear, giving the expected and received values.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous active-high reset
//   clear            synchronous clear of state and counters (beats in_valid)
//   in_valid/in_data stream sample
//   locked           checker is tracking the ramp
//   err_pulse        one-cycle pulse after a mismatching sample
//   match_count      matching samples seen while locked (saturating)
//   err_count        mismatching samples seen while locked (saturating)
//   wrap_count       matched samples equal to 2^WIDTH-1 (saturating)
//   first_err_*      first-error record (RAMP_CHK_ERR_LOG_EN only)
module ramp_stream_checker #(
  parameter int WIDTH         = 8,
  parameter int CNT_W         = 16,
  parameter int RESYNC_THRESH = 3   // 1..15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
`ifdef RAMP_CHK_ERR_LOG_EN
  ,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
`endif
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [4:0]       THRESH  = 5'(RESYNC_THRESH);
  localparam logic [WIDTH-1:0] TOP_VAL = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [3:0]       consec_q, consec_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] wrap_q, wrap_d;
  logic [4:0]       consec_inc;

`ifdef RAMP_CHK_ERR_LOG_EN
  logic             fe_valid_q, fe_valid_d;
  logic [WIDTH-1:0] fe_exp_q, fe_exp_d;
  logic [WIDTH-1:0] fe_got_q, fe_got_d;
`endif

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign consec_inc = {1'b0, consec_q} + 5'd1;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    consec_d    = consec_q;
    err_pulse_d = 1'b0;
    match_d     = match_q;
    err_d       = err_q;
    wrap_d      = wrap_q;
`ifdef RAMP_CHK_ERR_LOG_EN
    fe_valid_d  = fe_valid_q;
    fe_exp_d    = fe_exp_q;
    fe_got_d    = fe_got_q;
`endif
    if (clear) begin
      state_d  = UNLOCKED;
      exp_d    = '0;
      consec_d = '0;
      match_d  = '0;
      err_d    = '0;
      wrap_d   = '0;
`ifdef RAMP_CHK_ERR_LOG_EN
      fe_valid_d = 1'b0;
      fe_exp_d   = '0;
      fe_got_d   = '0;
`endif
    end else if (in_valid) begin
      case (state_q)
        UNLOCKED: begin
          // First sample after unlock seeds the expected sequence.
          exp_d    = in_data + WIDTH'(1);
          consec_d = '0;
          state_d  = LOCKED;
        end
        default: begin
          // Expected value advances on every sample; a bad sample does not
          // re-seed, so a single corrupted byte costs exactly one error.
          exp_d = exp_q + WIDTH'(1);
          if (in_data == exp_q) begin
            match_d  = sat_inc(match_q);
            consec_d = '0;
            if (in_data == TOP_VAL) wrap_d = sat_inc(wrap_q);
          end else begin
            err_d       = sat_inc(err_q);
            err_pulse_d = 1'b1;
            if (consec_inc == THRESH) begin
              state_d  = UNLOCKED;
              consec_d = '0;
            end else begin
              consec_d = consec_inc[3:0];
            end
`ifdef RAMP_CHK_ERR_LOG_EN
            if (!fe_valid_q) begin
              fe_valid_d = 1'b1;
              fe_exp_d   = exp_q;
              fe_got_d   = in_data;
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      exp_q       <= '0;
      consec_q    <= '0;
      err_pulse_q <= 1'b0;
      match_q     <= '0;
      err_q       <= '0;
      wrap_q      <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      consec_q    <= consec_d;
      err_pulse_q <= err_pulse_d;
      match_q     <= match_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign err_pulse   = err_pulse_q;
  assign match_count = match_q;
  assign err_count   = err_q;
  assign wrap_count  = wrap_q;

`ifdef RAMP_CHK_ERR_LOG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fe_valid_q <= 1'b0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_exp_q   <= fe_exp_d;
      fe_got_q   <= fe_got_d;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_got   = fe_got_q;
`endif

endmodule

// File: tb/tb_ramp_stream_checker.sv
module tb_ramp_stream_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        locked, err_pulse;
  logic [15:0] match_count, err_count, wrap_count;
  logic        s_locked, s_err_pulse;
  logic [3:0]  s_match, s_err, s_wrap;
`ifdef RAMP_CHK_ERR_LOG_EN
  logic        fe_valid, s_fe_valid;
  logic [7:0]  fe_exp, fe_got, s_fe_exp, s_fe_got;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ramp_stream_checker #(.WIDTH(8), .CNT_W(16), .RESYNC_THRESH(3)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err_pulse(err_pulse),
    .match_count(match_count), .err_count(err_count), .wrap_count(wrap_count)
`ifdef RAMP_CHK_ERR_LOG_EN
    , .first_err_valid(fe_valid), .first_err_exp(fe_exp), .first_err_got(fe_got)
`endif
  );

  // Narrow-counter instance sharing the stimulus, used for saturation.
  ramp_stream_checker #(.WIDTH(8), .CNT_W(4), .RESYNC_THRESH(3)) u_sat (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data),
    .locked(s_locked), .err_pulse(s_err_pulse),
    .match_count(s_match), .err_count(s_err), .wrap_count(s_wrap)
`ifdef RAMP_CHK_ERR_LOG_EN
    , .first_err_valid(s_fe_valid), .first_err_exp(s_fe_exp), .first_err_got(s_fe_got)
`endif
  );

  // One clock with the given inputs; returns #1 after the edge.
  task automatic cycle(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle(1'b0, 8'h00);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({locked, err_pulse, match_count, err_count, wrap_count} !== 50'd0) begin
      failures++;
      $display("FAIL reset_outputs got locked=%b pulse=%b m=%0d e=%0d w=%0d want all 0",
               locked, err_pulse, match_count, err_count, wrap_count);
    end
`ifdef RAMP_CHK_ERR_LOG_EN
    checks++;
    if ({fe_valid, fe_exp, fe_got} !== 17'd0) begin
      failures++;
      $display("FAIL reset_first_err got %b/%0d/%0d want 0", fe_valid, fe_exp, fe_got);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_full_ramp();
    int pulses = 0;
    for (int i = 0; i < 266; i++) begin
      cycle(1'b1, 8'(i));
      if (err_pulse) pulses++;
      if (i == 0) begin
        checks++;
        if (locked !== 1'b1) begin
          failures++;
          $display("FAIL ramp_lock_first_edge got %b want 1", locked);
        end
      end
    end
    checks++;
    if (match_count !== 16'd265) begin
      failures++;
      $display("FAIL ramp_match got %0d want 265", match_count);
    end
    checks++;
    if (err_count !== 16'd0) begin
      failures++;
      $display("FAIL ramp_err got %0d want 0", err_count);
    end
    checks++;
    if (wrap_count !== 16'd1) begin
      failures++;
      $display("FAIL ramp_wrap got %0d want 1", wrap_count);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL ramp_no_pulse got %0d pulses want 0", pulses);
    end
  endtask

  // One corrupted sample (8 received as 9); the stream then carries on at 9.
  task automatic test_single_error();
    logic [7:0] stim [6];
    logic       pulse_seen [6];
    stim = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd9, 8'd10};
    do_clear();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, stim[i]);
      pulse_seen[i] = err_pulse;
    end
    cycle(1'b0, 8'h00);
    checks++;
    if ({pulse_seen[0], pulse_seen[1], pulse_seen[2], pulse_seen[3], pulse_seen[4],
         pulse_seen[5], err_pulse} !== 7'b0001000) begin
      failures++;
      $display("FAIL single_err_pulse got %b%b%b%b%b%b%b want 0001000",
               pulse_seen[0], pulse_seen[1], pulse_seen[2], pulse_seen[3],
               pulse_seen[4], pulse_seen[5], err_pulse);
    end
    checks++;
    if (err_count !== 16'd1 || match_count !== 16'd4 || locked !== 1'b1) begin
      failures++;
      $display("FAIL single_err_counts got e=%0d m=%0d l=%b want e=1 m=4 l=1",
               err_count, match_count, locked);
    end
`ifdef RAMP_CHK_ERR_LOG_EN
    checks++;
    if (fe_valid !== 1'b1 || fe_exp !== 8'd8 || fe_got !== 8'd9) begin
      failures++;
      $display("FAIL first_err_record got %b/%0d/%0d want 1/8/9", fe_valid, fe_exp, fe_got);
    end
`endif
  endtask

  task automatic test_resync();
    do_clear();
    cycle(1'b1, 8'd0);
    cycle(1'b1, 8'd1);
    cycle(1'b1, 8'd2);
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'h55);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL resync_still_locked got %b want 1", locked);
    end
    cycle(1'b1, 8'h55);
    checks++;
    if (locked !== 1'b0 || err_count !== 16'd3) begin
      failures++;
      $display("FAIL resync_unlock got l=%b e=%0d want l=0 e=3", locked, err_count);
    end
    cycle(1'b1, 8'd20);
    cycle(1'b1, 8'd21);
    checks++;
    if (err_count !== 16'd3 || match_count !== 16'd3 || locked !== 1'b1) begin
      failures++;
      $display("FAIL resync_final got e=%0d m=%0d l=%b want e=3 m=3 l=1",
               err_count, match_count, locked);
    end
`ifdef RAMP_CHK_ERR_LOG_EN
    checks++;
    if (fe_valid !== 1'b1 || fe_exp !== 8'd3 || fe_got !== 8'h55) begin
      failures++;
      $display("FAIL resync_first_err got %b/%0d/%0d want 1/3/85", fe_valid, fe_exp, fe_got);
    end
`endif
  endtask

  task automatic test_gaps();
    do_clear();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 8'(i));
      cycle(1'b0, 8'hAA);
    end
    checks++;
    if (err_count !== 16'd0 || match_count !== 16'd99) begin
      failures++;
      $display("FAIL gaps got e=%0d m=%0d want e=0 m=99", err_count, match_count);
    end
  endtask

  task automatic test_clear_mid_stream();
    do_clear();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i));
    clear = 1'b1;
    cycle(1'b1, 8'd10);
    clear = 1'b0;
    checks++;
    if ({locked, err_pulse, match_count, err_count, wrap_count} !== 50'd0) begin
      failures++;
      $display("FAIL clear_outputs got l=%b m=%0d e=%0d want 0", locked, match_count, err_count);
    end
    cycle(1'b1, 8'd77);
    cycle(1'b1, 8'd78);
    checks++;
    if (locked !== 1'b1 || match_count !== 16'd1 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL clear_reseed got l=%b m=%0d e=%0d want l=1 m=1 e=0",
               locked, match_count, err_count);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i));
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({locked, match_count} !== 17'd0) begin
      failures++;
      $display("FAIL async_reset got l=%b m=%0d want 0", locked, match_count);
    end
    #1;
    reset = 1'b0;
    cycle(1'b1, 8'd30);
    cycle(1'b1, 8'd31);
    checks++;
    if (locked !== 1'b1 || match_count !== 16'd1) begin
      failures++;
      $display("FAIL async_relock got l=%b m=%0d want l=1 m=1", locked, match_count);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i));
    checks++;
    if (s_match !== 4'd15) begin
      failures++;
      $display("FAIL sat_match got %0d want 15", s_match);
    end
    checks++;
    if (match_count !== 16'd19) begin
      failures++;
      $display("FAIL wide_match got %0d want 19", match_count);
    end
  endtask

  initial begin
    test_reset();
    test_full_ramp();
    test_single_error();
    test_resync();
    test_gaps();
    test_clear_mid_stream();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
